// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - load/store sequencer between the CPU and a ready-handshake data memory
//
// Accepts one CPU load/store at a time, rejects misaligned or illegal sizes
// without touching memory, drives a word-aligned memory request with byte
// enables and lane-replicated write data, waits for mem_ready (bounded by
// TIMEOUT cycles), and returns extended load data with a one-cycle done pulse.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   cpu_req/we/size/sext/addr/wdata  CPU request (held until cpu_done)
//   cpu_rdata/done/err/err_code   completion result (valid while cpu_done)
//   cpu_stall                     cpu_req & ~cpu_done
//   mem_req/we/addr/be/wdata      memory request, held until ready or abort
//   mem_rdata/ready               memory response
module dmem_access_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [1:0]       cpu_size,
    input  logic             cpu_sext,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_wdata,
    output logic [31:0]      cpu_rdata,
    output logic             cpu_done,
    output logic             cpu_err,
    output logic [1:0]       cpu_err_code,
    output logic             cpu_stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [3:0]       mem_be,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0] cnt;
    logic             timeout_hit;

    // Attributes of the accepted request, kept for the read extender.
    logic             lat_we;
    logic [1:0]       lat_size;
    logic             lat_sext;
    logic [1:0]       lat_lane;

    // Request decode, evaluated against the live CPU inputs in IDLE.
    logic             bad_align;
    logic [3:0]       req_be;
    logic [31:0]      req_wdata;

    always_comb begin
        bad_align = 1'b0;
        req_be    = 4'b0000;
        req_wdata = cpu_wdata;
        case (cpu_size)
            2'b00: begin
                req_be    = 4'b0001 << cpu_addr[1:0];
                req_wdata = {4{cpu_wdata[7:0]}};
            end
            2'b01: begin
                bad_align = cpu_addr[0];
                req_be    = 4'b0011 << {cpu_addr[1], 1'b0};
                req_wdata = {2{cpu_wdata[15:0]}};
            end
            2'b10: begin
                bad_align = |cpu_addr[1:0];
                req_be    = 4'b1111;
            end
            default: bad_align = 1'b1;
        endcase
    end

    // Read extender: pick the addressed lane out of the returned word.
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_ext;

    always_comb begin
        rd_byte  = mem_rdata[{lat_lane, 3'b000} +: 8];
        rd_half  = mem_rdata[{lat_lane[1], 4'b0000} +: 16];
        load_ext = mem_rdata;
        case (lat_size)
            2'b00:   load_ext = lat_sext ? {{24{rd_byte[7]}}, rd_byte} : {24'b0, rd_byte};
            2'b01:   load_ext = lat_sext ? {{16{rd_half[15]}}, rd_half} : {16'b0, rd_half};
            default: load_ext = mem_rdata;
        endcase
    end

    // The wait that would make the count reach TIMEOUT is the last one allowed.
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cpu_req) begin
                    state_nxt = bad_align ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (mem_ready || timeout_hit) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Registered datapath; memory outputs are cleared when the request ends
    // and CPU result fields are only non-zero during the DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'h0;
            mem_be       <= 4'b0000;
            mem_wdata    <= 32'h0;
            cpu_rdata    <= 32'h0;
            cpu_err      <= 1'b0;
            cpu_err_code <= 2'b00;
            cnt          <= '0;
            lat_we       <= 1'b0;
            lat_size     <= 2'b00;
            lat_sext     <= 1'b0;
            lat_lane     <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (cpu_req) begin
                        if (bad_align) begin
                            cpu_err      <= 1'b1;
                            cpu_err_code <= 2'b01;
                            cpu_rdata    <= 32'h0;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= cpu_we;
                            mem_addr  <= {cpu_addr[31:2], 2'b00};
                            mem_be    <= req_be;
                            mem_wdata <= req_wdata;
                            lat_we    <= cpu_we;
                            lat_size  <= cpu_size;
                            lat_sext  <= cpu_sext;
                            lat_lane  <= cpu_addr[1:0];
                        end
                    end
                end
                S_BUSY: begin
                    if (mem_ready || timeout_hit) begin
                        mem_req      <= 1'b0;
                        mem_we       <= 1'b0;
                        mem_addr     <= 32'h0;
                        mem_be       <= 4'b0000;
                        mem_wdata    <= 32'h0;
                        cnt          <= '0;
                        cpu_err      <= !mem_ready;
                        cpu_err_code <= mem_ready ? 2'b00 : 2'b10;
                        cpu_rdata    <= (mem_ready && !lat_we) ? load_ext : 32'h0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    cnt          <= '0;
                    cpu_err      <= 1'b0;
                    cpu_err_code <= 2'b00;
                    cpu_rdata    <= 32'h0;
                end
            endcase
        end
    end

    assign cpu_done  = (state == S_DONE);
    assign cpu_stall = cpu_req & ~cpu_done;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - self-checking bench for dmem_access_ctrl
module tb_dmem_access_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, cpu_sext;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_done, cpu_err, cpu_stall;
    logic [1:0]  cpu_err_code;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_ready;

    dmem_access_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_sext(cpu_sext),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_err_code(cpu_err_code),
        .cpu_stall(cpu_stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Per-cycle expectations, written by the transaction task from the model.
    logic        chk_en = 1'b0;
    logic        e_req, e_we, e_done, e_err, e_stall;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_be;
    logic [1:0]  e_code;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_req", 32'(mem_req), 32'(e_req));
            chk("cpu_done", 32'(cpu_done), 32'(e_done));
            chk("cpu_stall", 32'(cpu_stall), 32'(e_stall));
            if (e_req) begin
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_be", 32'(mem_be), 32'(e_be));
                chk("mem_we", 32'(mem_we), 32'(e_we));
                chk("mem_wdata", mem_wdata, e_wdata);
            end
            if (e_done) begin
                chk("cpu_err", 32'(cpu_err), 32'(e_err));
                chk("cpu_err_code", 32'(cpu_err_code), 32'(e_code));
                chk("cpu_rdata", cpu_rdata, e_rdata);
            end
        end
    end

    task automatic set_idle_exp();
        e_req = 1'b0; e_done = 1'b0; e_stall = 1'b0;
        e_we = 1'b0; e_err = 1'b0; e_code = 2'b00;
        e_addr = '0; e_wdata = '0; e_rdata = '0; e_be = '0;
    endtask

    // One CPU transaction; the memory answers after 'waits' not-ready cycles
    // (waits >= TIMEOUT means it never answers). Returns the model's load
    // result and what the DUT actually showed.
    task automatic run_txn(input logic we, input logic [1:0] size, input logic sext,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                           input int waits,
                           output logic [31:0] m_rdata, output logic [31:0] g_rdata,
                           output logic [3:0] g_be, output logic [31:0] g_wdata,
                           output logic [31:0] g_addr, output int g_done, output int g_reqs);
        int          lane, nbusy, c;
        logic        illegal, tmo;
        logic [31:0] v, be32, wexp;

        lane    = int'(addr & 32'd3);
        illegal = (size == 2'b11) || (size == 2'b01 && addr % 2 != 0) ||
                  (size == 2'b10 && addr % 4 != 0);
        tmo     = !illegal && waits >= TIMEOUT;
        nbusy   = illegal ? 0 : (tmo ? TIMEOUT : waits + 1);
        case (size)
            2'b00:   begin be32 = 32'd1 << lane;       wexp = (wd & 32'hFF) * 32'h0101_0101; end
            2'b01:   begin be32 = 32'd3 << (lane & 2); wexp = (wd & 32'hFFFF) * 32'h0001_0001; end
            default: begin be32 = 32'd15;              wexp = wd; end
        endcase
        if (size == 2'b00) begin
            v = (rd >> (8 * lane)) & 32'hFF;
            if (sext && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (size == 2'b01) begin
            v = (rd >> (8 * lane)) & 32'hFFFF;
            if (sext && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        m_rdata = (we || illegal || tmo) ? 32'h0 : v;

        g_rdata = 32'hXXXX_XXXX; g_be = 4'h0; g_wdata = '0; g_addr = '0;
        g_done = -1; g_reqs = 0;

        // cycle 0: request presented; ready here must be ignored
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_size = size; cpu_sext = sext;
        cpu_addr = addr; cpu_wdata = wd;
        mem_ready = 1'b1; mem_rdata = 32'h1357_9BDF;
        set_idle_exp(); e_stall = 1'b1;
        c = 0;
        @(negedge clk);
        for (int k = 1; k <= nbusy + 2; k++) begin
            @(posedge clk); #1;
            c = k;
            if (k <= nbusy) begin
                e_req = 1'b1; e_addr = addr & 32'hFFFF_FFFC; e_be = be32[3:0];
                e_we = we; e_wdata = wexp; e_stall = 1'b1;
                mem_ready = (k == waits + 1);
                mem_rdata = mem_ready ? rd : 32'h5A5A_5A5A;
            end else if (k == nbusy + 1) begin
                e_req = 1'b0; e_done = 1'b1; e_stall = 1'b0;
                e_err = illegal || tmo; e_code = illegal ? 2'b01 : (tmo ? 2'b10 : 2'b00);
                e_rdata = m_rdata;
                mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
            end else begin
                cpu_req = 1'b0; mem_ready = 1'b0;
                set_idle_exp();
            end
            @(negedge clk);
            if (mem_req) begin
                if (g_reqs == 0) begin g_be = mem_be; g_wdata = mem_wdata; g_addr = mem_addr; end
                g_reqs++;
            end
            if (cpu_done) begin g_done = c; g_rdata = cpu_rdata; end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] m_rd, g_rd, g_wd, g_ad;
    logic [3:0]  g_be;
    int          g_dn, g_rq;

    initial begin
        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'b00; cpu_sext = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
        set_idle_exp();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst mem_req", 32'(mem_req), 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst mem_be", 32'(mem_be), 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        chk("rst cpu_done", 32'(cpu_done), 32'd0);
        chk("rst cpu_err", 32'({cpu_err, cpu_err_code}), 32'd0);
        chk("rst cpu_rdata", cpu_rdata, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_en = 1'b1;

        // lb 0x1003, zero wait
        run_txn(1'b0, 2'b00, 1'b1, 32'h1003, 32'h0, 32'h80AA_BBCC, 0, m_rd, g_rd, g_be, g_wd, g_ad, g_dn, g_rq);
        chk("lb model", m_rd, 32'hFFFF_FF80);
        chk("lb rdata", g_rd, 32'hFFFF_FF80);
        chk("lb be", 32'(g_be), 32'b1000);
        chk("lb addr", g_ad, 32'h1000);
        chk("lb done cycle", 32'(g_dn), 32'd2);
        // lbu
        run_txn(1'b0, 2'b00, 1'b0, 32'h1003, 32'h0, 32'h80AA_BBCC, 0, m_rd, g_rd, g_be, g_wd, g_ad, g_dn, g_rq);
        chk("lbu rdata", g_rd, 32'h0000_0080);
        // lh 0x2002, 3 waits
        run_txn(1'b0, 2'b01, 1'b1, 32'h2002, 32'h0, 32'h8001_7FFF, 3, m_rd, g_rd, g_be, g_wd, g_ad, g_dn, g_rq);
        chk("lh model", m_rd, 32'hFFFF_8001);
        chk("lh rdata", g_rd, 32'hFFFF_8001);
        chk("lh be", 32'(g_be), 32'b1100);
        chk("lh done cycle", 32'(g_dn), 32'd5);
        // lhu 0x2000
        run_txn(1'b0, 2'b01, 1'b0, 32'h2000, 32'h0, 32'h8001_7FFF, 0, m_rd, g_rd, g_be, g_wd, g_ad, g_dn, g_rq);
        chk("lhu rdata", g_rd, 32'h0000_7FFF);
        // stores
        run_txn(1'b1, 2'b00, 1'b0, 32'h3001, 32'h1234_56AB, 32'hFFFF_FFFF, 1, m_rd, g_rd, g_be, g_wd, g_ad, g_dn, g_rq);
        chk("sb be", 32'(g_be), 32'b0010);
        chk("sb wdata", g_wd, 32'hABAB_ABAB);
        chk("sb rdata", g_rd, 32'h0);
        run_txn(1'b1, 2'b01, 1'b0, 32'h3002, 32'h1234_56AB, 32'h0, 0, m_rd, g_rd, g_be, g_wd, g_ad, g_dn, g_rq);
        chk("sh be", 32'(g_be), 32'b1100);
        chk("sh wdata", g_wd, 32'h56AB_56AB);
        run_txn(1'b1, 2'b10, 1'b0, 32'h3000, 32'h1234_56AB, 32'h0, 2, m_rd, g_rd, g_be, g_wd, g_ad, g_dn, g_rq);
        chk("sw be", 32'(g_be), 32'b1111);
        chk("sw wdata", g_wd, 32'h1234_56AB);
        // misaligned / illegal
        run_txn(1'b0, 2'b10, 1'b0, 32'h4002, 32'h0, 32'h0, 0, m_rd, g_rd, g_be, g_wd, g_ad, g_dn, g_rq);
        chk("lw mis reqs", 32'(g_rq), 32'd0);
        chk("lw mis done cycle", 32'(g_dn), 32'd1);
        run_txn(1'b1, 2'b01, 1'b0, 32'h4001, 32'hFFFF, 32'h0, 0, m_rd, g_rd, g_be, g_wd, g_ad, g_dn, g_rq);
        chk("sh mis reqs", 32'(g_rq), 32'd0);
        chk("sh mis done cycle", 32'(g_dn), 32'd1);
        run_txn(1'b0, 2'b11, 1'b0, 32'h4000, 32'h0, 32'h0, 0, m_rd, g_rd, g_be, g_wd, g_ad, g_dn, g_rq);
        chk("size11 reqs", 32'(g_rq), 32'd0);
        // timeout
        run_txn(1'b0, 2'b10, 1'b0, 32'h5000, 32'h0, 32'hCAFE_F00D, TIMEOUT, m_rd, g_rd, g_be, g_wd, g_ad, g_dn, g_rq);
        chk("tmo reqs", 32'(g_rq), 32'd16);
        chk("tmo done cycle", 32'(g_dn), 32'd17);
        chk("tmo rdata", g_rd, 32'h0);
        // normal after timeout
        run_txn(1'b0, 2'b10, 1'b0, 32'h5004, 32'h0, 32'hCAFE_F00D, 1, m_rd, g_rd, g_be, g_wd, g_ad, g_dn, g_rq);
        chk("lw after tmo", g_rd, 32'hCAFE_F00D);
        chk("lw after tmo done", 32'(g_dn), 32'd3);

        // asynchronous reset mid-BUSY
        chk_en = 1'b0;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b10; cpu_addr = 32'h6000; mem_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre-rst mem_req", 32'(mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst mem_req", 32'(mem_req), 32'd0);
        chk("async rst cpu_done", 32'(cpu_done), 32'd0);
        chk("async rst mem_be", 32'(mem_be), 32'd0);
        chk("async rst mem_addr", mem_addr, 32'd0);
        cpu_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_idle_exp();
        chk_en = 1'b1;
        run_txn(1'b0, 2'b00, 1'b1, 32'h6001, 32'h0, 32'h1234_7F00, 0, m_rd, g_rd, g_be, g_wd, g_ad, g_dn, g_rq);
        chk("lb after rst", g_rd, 32'h0000_007F);
        chk("lb after rst done", 32'(g_dn), 32'd2);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
